// File: rtl/mock_cu_multi_if.sv
// mock_cu_multi_if
// Parallel Channel "B" bus and tag bundle between a channel and a control unit.
//   master : channel side. Drives bus-out and the channel tags, and receives bus-in and the CU tags.
//   slave  : control-unit side. Uses the opposite directions.
interface mock_cu_multi_if;
  logic [7:0] b_bus_out;
  logic       b_operational_out;
  logic       b_hold_out;
  logic       b_select_out;
  logic       b_address_out;
  logic       b_command_out;
  logic       b_service_out;
  logic       b_suppress_out;

  logic [7:0] b_bus_in;
  logic       b_operational_in;
  logic       b_select_in;
  logic       b_address_in;
  logic       b_status_in;
  logic       b_service_in;
  logic       b_request_in;

  modport master (
    output b_bus_out, b_operational_out, b_hold_out, b_select_out,
           b_address_out, b_command_out, b_service_out, b_suppress_out,
    input  b_bus_in, b_operational_in, b_select_in, b_address_in,
           b_status_in, b_service_in, b_request_in
  );

  modport slave (
    input  b_bus_out, b_operational_out, b_hold_out, b_select_out,
           b_address_out, b_command_out, b_service_out, b_suppress_out,
    output b_bus_in, b_operational_in, b_select_in, b_address_in,
           b_status_in, b_service_in, b_request_in
  );
endinterface

// File: rtl/mock_cu_multi.sv
// mock_cu_multi
// Mock control unit on Channel "B". It answers NUM_DEVICES consecutive addresses that start at
// BASE_ADDRESS. For each device it runs initial selection, the command, the data transfer and the
// ending status. Each device has its own busy input and its own sense byte. Selections that this
// unit does not claim are passed on to Channel "A".
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   b               channel bus/tag bundle (slave modport)
//   a_select_out    select passed on to Channel "A"
//   a_select_in     select returned from Channel "A"; a registered copy drives b_select_in
//   mock_busy       per-device busy
//   mock_limit      bytes per READ/WRITE
//   command         last accepted command
//   device          index of the selected device
//   count           bytes transferred in the current operation (saturating)
//   write_checksum  XOR of the bytes received in the current WRITE
// Optional feature: define MOCK_CU_SHORT_BUSY_EN to answer a busy device with short-busy status
// (0x0A) instead of a full selection.
module mock_cu_multi #(
  parameter logic [7:0] BASE_ADDRESS = 8'h10,
  parameter int         NUM_DEVICES  = 4,
  parameter int         COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mock_cu_multi_if.slave         b,
  output logic                   a_select_out,
  input  logic                   a_select_in,
  input  logic [NUM_DEVICES-1:0] mock_busy,
  input  logic [COUNT_WIDTH-1:0] mock_limit,
  output logic [7:0]             command,
  output logic [3:0]             device,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [7:0]             write_checksum
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SEL   = 4'd1;
  localparam logic [3:0] ST_ADDR  = 4'd2;
  localparam logic [3:0] ST_CMDW  = 4'd3;
  localparam logic [3:0] ST_DEC   = 4'd4;
  localparam logic [3:0] ST_IST   = 4'd5;
  localparam logic [3:0] ST_ISTD  = 4'd6;
  localparam logic [3:0] ST_DATA  = 4'd7;
  localparam logic [3:0] ST_DATW  = 4'd8;
  localparam logic [3:0] ST_STOPW = 4'd9;
  localparam logic [3:0] ST_END   = 4'd10;
  localparam logic [3:0] ST_SBSY  = 4'd11;

  localparam logic [7:0] CMD_TIO   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_NOP   = 8'h03;
  localparam logic [7:0] CMD_SENSE = 8'h04;

  logic [3:0]  state;
  logic [7:0]  status;
  logic        select_in_q;
  logic [7:0]  sense [16];
  logic [8:0]  offset;
  logic        in_range;
  logic [15:0] busy_ext;
  logic [7:0]  own_addr;
  logic [7:0]  data_byte;
  logic        unused_bits;

  // The offset is computed in 9 bits, so an address past the block cannot wrap back into it.
  assign offset   = {1'b0, b.b_bus_out} - {1'b0, BASE_ADDRESS};
  assign in_range = (b.b_bus_out >= BASE_ADDRESS) && (offset < 9'(NUM_DEVICES));
  assign busy_ext = 16'(mock_busy);
  assign own_addr = BASE_ADDRESS + {4'h0, device};

  assign b.b_request_in = 1'b0;
  assign b.b_select_in  = select_in_q;
  assign unused_bits    = ^{b.b_hold_out, b.b_suppress_out, offset[8:4]};

  always_comb begin
    data_byte = 8'h00;
    if (command == CMD_READ)
      data_byte = (count[7:0] + 8'd1) ^ {4'h0, device};
    else if (command == CMD_SENSE)
      data_byte = sense[device];
  end

  // The CU tags and bus-in depend only on the state. Reset, or operational-out going low,
  // therefore clears them as soon as the state returns to IDLE.
  always_comb begin
    b.b_bus_in         = 8'h00;
    b.b_operational_in = 1'b0;
    b.b_address_in     = 1'b0;
    b.b_status_in      = 1'b0;
    b.b_service_in     = 1'b0;
    case (state)
      ST_SEL, ST_CMDW, ST_DEC, ST_ISTD, ST_DATW, ST_STOPW:
        b.b_operational_in = 1'b1;
      ST_ADDR: begin
        b.b_operational_in = 1'b1;
        b.b_bus_in         = own_addr;
        b.b_address_in     = 1'b1;
      end
      ST_IST: begin
        b.b_operational_in = 1'b1;
        b.b_bus_in         = status;
        b.b_status_in      = 1'b1;
      end
      ST_DATA: begin
        b.b_operational_in = 1'b1;
        b.b_bus_in         = data_byte;
        b.b_service_in     = 1'b1;
      end
      ST_END: begin
        b.b_operational_in = 1'b1;
        b.b_bus_in         = 8'h30;
        b.b_status_in      = 1'b1;
      end
      ST_SBSY: begin
        b.b_bus_in    = 8'h0A;
        b.b_status_in = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      status         <= 8'h00;
      command        <= 8'h00;
      device         <= 4'h0;
      count          <= '0;
      write_checksum <= 8'h00;
      a_select_out   <= 1'b0;
      select_in_q    <= 1'b0;
      for (int i = 0; i < 16; i++) sense[i] <= 8'h00;
    end else begin
      select_in_q  <= a_select_in;
      a_select_out <= 1'b0;
      if (!b.b_operational_out) begin
        state       <= ST_IDLE;
        select_in_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (b.b_address_out && b.b_select_out && in_range) begin
              device <= offset[3:0];
`ifdef MOCK_CU_SHORT_BUSY_EN
              state  <= busy_ext[offset[3:0]] ? ST_SBSY : ST_SEL;
`else
              state  <= ST_SEL;
`endif
            end else begin
              a_select_out <= b.b_select_out;
            end
          end
          ST_SEL:   if (!b.b_address_out) state <= ST_ADDR;
          ST_ADDR: begin
            if (b.b_command_out) begin
              command <= b.b_bus_out;
              state   <= ST_CMDW;
            end
          end
          ST_CMDW:  if (!b.b_command_out) state <= ST_DEC;
          // Busy takes priority over any command decode. An unknown command also sets
          // command-reject in the device's sense byte.
          ST_DEC: begin
            state <= ST_IST;
            if (busy_ext[device]) begin
              status <= 8'h08;
            end else begin
              case (command)
                CMD_TIO, CMD_WRITE, CMD_READ, CMD_SENSE: status <= 8'h00;
                CMD_NOP: status <= 8'h30;
                default: begin
                  status        <= 8'h70;
                  sense[device] <= sense[device] | 8'h01;
                end
              endcase
            end
          end
          ST_IST:   if (b.b_service_out) state <= ST_ISTD;
          ST_ISTD: begin
            if (!b.b_service_out) begin
              if (status[3] || (status[4] && status[5]) || command == CMD_TIO) begin
                state <= ST_IDLE;
              end else begin
                count          <= '0;
                write_checksum <= 8'h00;
                if (command != CMD_SENSE && mock_limit == '0)
                  state <= ST_END;
                else
                  state <= ST_DATA;
              end
            end
          end
          // If command-out arrives while service-in is up, the channel is stopping the
          // transfer. The offered byte is then not counted.
          ST_DATA: begin
            if (b.b_command_out) begin
              state <= ST_STOPW;
            end else if (b.b_service_out) begin
              if (count != '1) count <= count + COUNT_WIDTH'(1);
              if (command == CMD_WRITE) write_checksum <= write_checksum ^ b.b_bus_out;
              if (command == CMD_SENSE) sense[device] <= 8'h00;
              state <= ST_DATW;
            end
          end
          ST_DATW: begin
            if (!b.b_service_out)
              state <= (command == CMD_SENSE || count >= mock_limit) ? ST_END : ST_DATA;
          end
          ST_STOPW: if (!b.b_command_out) state <= ST_END;
          ST_END:   if (b.b_service_out) state <= ST_IDLE;
          ST_SBSY:  if (!b.b_address_out) state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mock_cu_multi.sv
// tb_mock_cu_multi
// Directed bench for mock_cu_multi. It plays the channel side of the handshake.
// The expected values are worked out by hand from the device behaviour.
// It also covers the MOCK_CU_SHORT_BUSY_EN variant.
module tb_mock_cu_multi;
  localparam int CW     = 16;
  localparam int OPIN   = 0;
  localparam int ADDRIN = 1;
  localparam int STATIN = 2;
  localparam int SVCIN  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_select_out;
  logic          a_select_in;
  logic [3:0]    mock_busy;
  logic [CW-1:0] mock_limit;
  logic [7:0]    command;
  logic [3:0]    device;
  logic [CW-1:0] count;
  logic [7:0]    write_checksum;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mock_cu_multi_if bif ();

  mock_cu_multi #(
    .BASE_ADDRESS(8'h10),
    .NUM_DEVICES (4),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .b             (bif),
    .a_select_out  (a_select_out),
    .a_select_in   (a_select_in),
    .mock_busy     (mock_busy),
    .mock_limit    (mock_limit),
    .command       (command),
    .device        (device),
    .count         (count),
    .write_checksum(write_checksum)
  );

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic get_tag(input int sel);
    case (sel)
      OPIN:    get_tag = bif.b_operational_in;
      ADDRIN:  get_tag = bif.b_address_in;
      STATIN:  get_tag = bif.b_status_in;
      SVCIN:   get_tag = bif.b_service_in;
      default: get_tag = 1'b0;
    endcase
  endfunction

  // Waits a bounded number of cycles for a CU tag. A timeout shows up as a failed check.
  task automatic wait_tag(input int sel, input logic val, input string name);
    int n = 0;
    while (get_tag(sel) !== val && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(get_tag(sel)), 32'(val));
  endtask

  task automatic apply_stimulus(input logic [7:0] bus, input logic sel, input logic adr,
                                input logic cmd, input logic svc);
    bif.b_bus_out     = bus;
    bif.b_select_out  = sel;
    bif.b_hold_out    = sel;
    bif.b_address_out = adr;
    bif.b_command_out = cmd;
    bif.b_service_out = svc;
  endtask

  task automatic initial_sel(input logic [7:0] addr, input logic [7:0] cmd,
                             input logic [7:0] exp_status, input logic [3:0] exp_dev);
    apply_stimulus(addr, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_tag(OPIN, 1'b1, "operational_in raise");
    check_output("device", 32'(device), 32'(exp_dev));
    apply_stimulus(addr, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_tag(ADDRIN, 1'b1, "address_in raise");
    check_output("address echo", 32'(bif.b_bus_in), 32'(addr));
    apply_stimulus(cmd, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_tag(ADDRIN, 1'b0, "address_in drop");
    check_output("command latch", 32'(command), 32'(cmd));
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_tag(STATIN, 1'b1, "initial status_in");
    check_output("initial status", 32'(bif.b_bus_in), 32'(exp_status));
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_tag(STATIN, 1'b0, "initial status_in drop");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_byte(input logic [7:0] exp, input string name);
    wait_tag(SVCIN, 1'b1, "read service_in");
    check_output(name, 32'(bif.b_bus_in), 32'(exp));
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_tag(SVCIN, 1'b0, "read service_in drop");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] data);
    wait_tag(SVCIN, 1'b1, "write service_in");
    apply_stimulus(data, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_tag(SVCIN, 1'b0, "write service_in drop");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic end_status();
    wait_tag(STATIN, 1'b1, "ending status_in");
    check_output("ending status", 32'(bif.b_bus_in), 32'h30);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_tag(STATIN, 1'b0, "ending status_in drop");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_tag(OPIN, 1'b0, "operational_in drop");
  endtask

  initial begin
    reset                 = 1'b1;
    bif.b_operational_out = 1'b1;
    bif.b_suppress_out    = 1'b0;
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    a_select_in = 1'b0;
    mock_busy   = 4'h0;
    mock_limit  = '0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    check_output("reset operational_in", 32'(bif.b_operational_in), 32'h0);
    check_output("reset status_in", 32'(bif.b_status_in), 32'h0);
    check_output("reset bus_in", 32'(bif.b_bus_in), 32'h0);
    check_output("reset request_in", 32'(bif.b_request_in), 32'h0);
    check_output("reset a_select_out", 32'(a_select_out), 32'h0);
    check_output("reset count", 32'(count), 32'h0);
    check_output("reset command", 32'(command), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] NOP on 0x11");
    initial_sel(8'h11, 8'h03, 8'h30, 4'd1);
    wait_tag(OPIN, 1'b0, "NOP back to idle");
    check_output("NOP count", 32'(count), 32'h0);

    $display("[TB] READ 3 bytes on 0x12");
    mock_limit = 16'd3;
    initial_sel(8'h12, 8'h02, 8'h00, 4'd2);
    read_byte(8'h03, "read byte 1");
    read_byte(8'h00, "read byte 2");
    read_byte(8'h01, "read byte 3");
    end_status();
    check_output("read count", 32'(count), 32'd3);

    $display("[TB] WRITE 4 bytes on 0x10");
    mock_limit = 16'd4;
    initial_sel(8'h10, 8'h01, 8'h00, 4'd0);
    write_byte(8'hA5);
    write_byte(8'h5A);
    check_output("write checksum after 2", 32'(write_checksum), 32'hFF);
    check_output("write count after 2", 32'(count), 32'd2);
    write_byte(8'hFF);
    write_byte(8'h00);
    end_status();
    check_output("write checksum", 32'(write_checksum), 32'h00);
    check_output("write count", 32'(count), 32'd4);

    $display("[TB] unknown command and SENSE on 0x13");
    initial_sel(8'h13, 8'h7F, 8'h70, 4'd3);
    wait_tag(OPIN, 1'b0, "reject back to idle");
    initial_sel(8'h13, 8'h04, 8'h00, 4'd3);
    read_byte(8'h01, "sense byte");
    end_status();
    initial_sel(8'h13, 8'h04, 8'h00, 4'd3);
    read_byte(8'h00, "sense byte repeat");
    end_status();

    $display("[TB] out of range 0x20");
    apply_stimulus(8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_output("pass a_select_out", 32'(a_select_out), 32'h1);
    check_output("pass operational_in", 32'(bif.b_operational_in), 32'h0);
    check_output("pass address_in", 32'(bif.b_address_in), 32'h0);
    check_output("pass status_in", 32'(bif.b_status_in), 32'h0);
    a_select_in = 1'b1;
    @(negedge clk);
    check_output("select_in copy", 32'(bif.b_select_in), 32'h1);
    a_select_in = 1'b0;
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("pass a_select_out drop", 32'(a_select_out), 32'h0);
    check_output("select_in copy drop", 32'(bif.b_select_in), 32'h0);

    $display("[TB] busy device 0x12");
    mock_busy = 4'b0100;
`ifdef MOCK_CU_SHORT_BUSY_EN
    apply_stimulus(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_tag(STATIN, 1'b1, "short busy status_in");
    check_output("short busy status", 32'(bif.b_bus_in), 32'h0A);
    check_output("short busy operational_in", 32'(bif.b_operational_in), 32'h0);
    apply_stimulus(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_tag(STATIN, 1'b0, "short busy release");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    initial_sel(8'h12, 8'h02, 8'h08, 4'd2);
    wait_tag(OPIN, 1'b0, "busy back to idle");
`endif
    mock_busy = 4'h0;

    $display("[TB] READ with zero limit on 0x11");
    mock_limit = '0;
    initial_sel(8'h11, 8'h02, 8'h00, 4'd1);
    end_status();
    check_output("zero limit count", 32'(count), 32'h0);

    $display("[TB] STOP during READ on 0x10");
    mock_limit = 16'd3;
    initial_sel(8'h10, 8'h02, 8'h00, 4'd0);
    read_byte(8'h01, "stop read byte 1");
    wait_tag(SVCIN, 1'b1, "stop service_in");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_tag(SVCIN, 1'b0, "stop service_in drop");
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end_status();
    check_output("stop count", 32'(count), 32'd1);

    $display("[TB] reset during READ byte 2");
    initial_sel(8'h12, 8'h02, 8'h00, 4'd2);
    read_byte(8'h03, "pre-reset byte 1");
    wait_tag(SVCIN, 1'b1, "pre-reset byte 2 service_in");
    check_output("pre-reset byte 2", 32'(bif.b_bus_in), 32'h00);
    reset = 1'b1;
    #1;
    check_output("mid reset operational_in", 32'(bif.b_operational_in), 32'h0);
    check_output("mid reset service_in", 32'(bif.b_service_in), 32'h0);
    check_output("mid reset bus_in", 32'(bif.b_bus_in), 32'h0);
    check_output("mid reset count", 32'(count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    initial_sel(8'h10, 8'h03, 8'h30, 4'd0);
    wait_tag(OPIN, 1'b0, "post-reset NOP idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mock_cu_multi.md
Name: mock_cu_multi

Overview:
Parametrised mock control unit on Parallel Channel "B" that answers a contiguous block of NUM_DEVICES device addresses instead of one. It runs the full initial-selection, command, data-transfer and ending-status sequence per device, with per-device busy, a SENSE command backed by a per-device sense byte, a deterministic read data pattern and a write checksum. Selection it does not claim passes to Channel "A". Used as bench stimulus for channel RTL.

Parameters:
BASE_ADDRESS, 8'h10, first device address claimed
NUM_DEVICES, 4, devices claimed (1..16); addresses BASE_ADDRESS..BASE_ADDRESS+NUM_DEVICES-1, no wrap past 8'hff
COUNT_WIDTH, 16, width of byte counter and limit

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
b_bus_out  in  8  channel bus-out
b_operational_out, b_hold_out, b_select_out, b_address_out, b_command_out, b_service_out, b_suppress_out  in  1 each  channel tags
b_bus_in  out  8  bus-in
b_operational_in, b_select_in, b_address_in, b_status_in, b_service_in, b_request_in  out  1 each  CU tags
a_select_out  out  1  select propagated to Channel "A"
a_select_in  in  1  select returned from Channel "A"
mock_busy  in  NUM_DEVICES  per-device busy
mock_limit  in  COUNT_WIDTH  bytes per READ/WRITE
command  out  8  last accepted command
device  out  4  index of selected device
count  out  COUNT_WIDTH  bytes transferred in current operation
write_checksum  out  8  XOR of bytes received in current WRITE

Behaviour:
- Reset: all outputs 0, state IDLE, all sense bytes 0. b_request_in is tied 0.
- Status bus encoding: bus[i] = IBM status bit i. SM=0x02, BUSY=0x08, CE=0x10, DE=0x20, UC=0x40.
- b_select_in is a one-cycle registered copy of a_select_in.
- b_operational_out low: next edge clears every CU tag out and returns to IDLE. Same for reset at any point, including mid-transfer.
- IDLE: if address_out && select_out && bus_out in range, latch device = bus_out-BASE_ADDRESS and go to SEL. Otherwise a_select_out <= b_select_out.
- SEL: operational_in=1. Wait for address_out low, then go to ADDR.
- ADDR: bus_in=own address, address_in=1. On command_out, latch command, drop address_in, go to CMDW.
- CMDW: wait for command_out low, then go to DEC.
- DEC (one cycle), status chosen in priority order:
  - mock_busy[device]: BUSY 0x08.
  - 00 TEST I/O: 0x00, no data.
  - 01 WRITE, 02 READ, 04 SENSE: 0x00.
  - 03 NOP: 0x30.
  - Any other command: 0x70 and sense[device] bit 0 (0x01) set.
- IST: bus_in=status, status_in=1. On service_out, drop status_in and go to ISTD.
- ISTD: wait for service_out low.
  - Status has BUSY, or both CE and DE, or is TEST I/O: go to IDLE.
  - Otherwise clear count and write_checksum and enter data phase.
  - If mock_limit==0 (READ/WRITE): go straight to END with 0x30.
- READ data: bus_in = (count[7:0]+1) ^ {4'h0,device}, service_in=1. On service_out: count+1, drop service_in, wait for service_out low, then repeat until count==mock_limit.
- WRITE data: same handshake. On service_out, write_checksum ^= bus_out and count+1.
- SENSE: one byte, bus_in=sense[device]. That sense byte clears on acceptance, then go to END.
- command_out while service_in is raised = STOP: drop service_in, wait for command_out low, go to END. Count reflects bytes accepted so far.
- END: bus_in=0x30, status_in=1. On service_out, drop status_in and go to IDLE.
- operational_in is held 1 from SEL through END, including the data phase. It clears in IDLE.
- count saturates at all-ones and never wraps.

Optional Feature:
MOCK_CU_SHORT_BUSY_EN. When defined, an in-range address with mock_busy[device] high triggers short busy: no operational_in, bus_in=0x0A, status_in=1 until address_out low, then IDLE. When undefined, busy devices take the full-selection path with status 0x08.

Test Plan:
- Select 8'h11, cmd 03, mock_busy=0: device=1, initial status 0x30, return to IDLE, count=0.
- Select 8'h12, cmd 02, limit=3: bytes 0x03,0x00,0x01 (device 2 XOR 1,2,3), ending status 0x30, count=3.
- Select 8'h10, cmd 01, limit=4, bytes A5,5A,FF,00: write_checksum=0x00, count=4, ending status 0x30.
- Select 8'h13, cmd 0x7F then cmd 04: first gives 0x70; SENSE returns 0x01, a repeat SENSE returns 0x00.
- Select 8'h20, out of range: a_select_out follows b_select_out; CU tags stay low.
- Assert reset during READ byte 2: all tags 0 immediately. After release, a NOP on 8'h10 completes normally.
